mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the max consecutive data-won conflict cycles before instruction fetch is forced to win (legal range 1..15).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all logic on posedge clk.
- resetn  in  1  synchronous, active-low reset.
- inst_req  in  1  fetch request.
- inst_addr  in  32  fetch byte address.
- inst_gnt  out  1  fetch accepted this cycle.
- inst_rvalid  out  1  fetch data valid.
- inst_rdata  out  32  fetch data, held.
- data_req  in  1  load/store request.
- data_wen  in  4  byte write enables; 0 = read.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_gnt  out  1  data accepted this cycle.
- data_rvalid  out  1  load data valid.
- data_rdata  out  32  load data, held.
- sram_en  out  1  unified SRAM enable.
- sram_wen  out  4  unified SRAM byte enables.
- sram_addr  out  32  unified SRAM address.
- sram_wdata  out  32  unified SRAM write data.
- sram_rdata  in  32  unified SRAM read data, valid 1 cycle after sram_en with sram_wen=0.
REQ-003 One clock; reset is synchronous and active-low, ports clk and resetn.

Function
REQ-004 Arbitration SHALL be combinational in the request cycle: data wins, unless inst_req=1 and starve_cnt==STARVE_LIMIT, in which case inst wins.
REQ-005 Exactly one of inst_gnt/data_gnt SHALL be 1 when any request is pending; both SHALL be 0 otherwise.
REQ-006 On inst_gnt: sram_en=1, sram_wen=0, sram_addr=inst_addr, sram_wdata=0.
REQ-007 On data_gnt: sram_en=1, sram_wen=data_wen, sram_addr=data_addr, sram_wdata=data_wdata.
REQ-008 With no grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
REQ-009 Requesters SHALL hold req/addr/wen/wdata stable until the grant; the arbiter SHALL not buffer ungranted requests.
REQ-010 The owner register SHALL take one of NONE, INST_RD, DATA_RD, DATA_WR each cycle, per the grant of the previous cycle.
REQ-011 Owner INST_RD: inst_rvalid=1 for one cycle and inst_rdata=sram_rdata captured; same for DATA_RD on the data port.
REQ-012 Owner DATA_WR or NONE SHALL produce no rvalid.
REQ-013 inst_rdata/data_rdata SHALL hold their last returned value until the next rvalid on that port.
REQ-014 Back-to-back grants SHALL be sustained at one per cycle; a grant and the rvalid of the previous grant coexist in the same cycle.
REQ-015 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, when inst_req=1 and data_gnt=1.
REQ-016 starve_cnt SHALL clear on inst_gnt=1 or inst_req=0.
REQ-017 There SHALL be no combinational path from sram_rdata to any grant or sram_* output.

Reset
REQ-018 While resetn=0, all outputs SHALL be 0, gnts forced 0 regardless of requests, owner=NONE, starve_cnt=0, hold registers=0.
REQ-019 Reset asserted mid-transfer SHALL suppress the pending rvalid; the first cycle after reset release SHALL show rvalid=0 on both ports.

Structure
REQ-020 Shared package mem_arb_pkg SHALL hold the owner enum (NONE, INST_RD, DATA_RD, DATA_WR) and the STARVE_LIMIT default.
REQ-021 Response routing and both hold registers SHALL form one sub-module, mem_arb_rsp; arbitration and starve counter stay in mem_arbiter.

Verification
REQ-022 Bench SHALL cover inst only:
- Stimulus: inst_req=1, addr 0xbfc00000, then 0xbfc00004 on the next cycle; SRAM returns 0x11111111, 0x22222222.
- Response: inst_gnt=1 both cycles; inst_rvalid=1 in cycles 2 and 3 with those values; inst_rdata holds 0x22222222 afterward.
REQ-023 Bench SHALL cover a load/fetch conflict:
- Stimulus: both requests for 1 cycle, data_wen=0.
- Response: data_gnt=1, inst_gnt=0; next cycle data_rvalid=1 and inst_gnt=1.
REQ-024 Bench SHALL cover starvation, STARVE_LIMIT=4:
- Stimulus: both requests held 6 cycles.
- Response: data_gnt cycles 1-4; inst_gnt cycle 5; data_gnt cycle 6.
REQ-025 Bench SHALL cover a store:
- Stimulus: data_req, data_wen=4'b0011, addr 0x100, wdata 0xdeadbeef.
- Response: sram_wen=4'b0011, sram_addr=0x100, sram_wdata=0xdeadbeef; no data_rvalid next cycle.
REQ-026 Bench SHALL cover reset mid-read:
- Stimulus: inst granted, then resetn=0 on the next cycle.
- Response: inst_rvalid=0, inst_rdata=0, starve_cnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified-SRAM arbiter.
//   owner_e          : who owns the SRAM read data returning this cycle
//   STARVE_LIMIT_DEF : default number of data-won conflicts before a fetch is forced
package mem_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        INST_RD = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_arb_rsp.sv
// mem_arb_rsp: response routing for the unified SRAM.
// Records which requester was granted last cycle (owner) and steers the
// returning SRAM read data to that port; each port keeps its last returned
// word in a hold register between responses.
//   clk, resetn          : clock, synchronous active-low reset
//   i_inst_gnt/data_gnt  : grants issued this cycle
//   i_data_wen           : data byte enables (0 = read)
//   i_sram_rdata         : SRAM read data for last cycle's access
//   o_inst_*/o_data_*    : per-port rvalid and held read data
module mem_arb_rsp
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_inst_gnt,
    input  logic        i_data_gnt,
    input  logic [3:0]  i_data_wen,
    input  logic [31:0] i_sram_rdata,
    output logic        o_inst_rvalid,
    output logic [31:0] o_inst_rdata,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata
);

    owner_e      r_owner;
    owner_e      w_owner_nxt;
    logic [31:0] r_inst_hold;
    logic [31:0] r_data_hold;
    logic        w_inst_rv;
    logic        w_data_rv;

    always_comb begin
        w_owner_nxt = NONE;
        if (i_inst_gnt)
            w_owner_nxt = INST_RD;
        else if (i_data_gnt)
            w_owner_nxt = (i_data_wen == 4'b0000) ? DATA_RD : DATA_WR;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner     <= NONE;
            r_inst_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (r_owner == INST_RD) r_inst_hold <= i_sram_rdata;
            if (r_owner == DATA_RD) r_data_hold <= i_sram_rdata;
        end
    end

    // Outputs are gated by resetn so they read 0 from the very first reset
    // cycle, not only after the synchronous clear has taken effect.
    assign w_inst_rv     = resetn && (r_owner == INST_RD);
    assign w_data_rv     = resetn && (r_owner == DATA_RD);
    assign o_inst_rvalid = w_inst_rv;
    assign o_data_rvalid = w_data_rv;

    // In the response cycle the live SRAM word is presented directly; it is
    // captured into the hold register at the end of that cycle.
    assign o_inst_rdata = !resetn ? '0 : (w_inst_rv ? i_sram_rdata : r_inst_hold);
    assign o_data_rdata = !resetn ? '0 : (w_data_rv ? i_sram_rdata : r_data_hold);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority arbiter (data over fetch) for one unified SRAM,
// with a starvation counter that forces a fetch grant after STARVE_LIMIT
// consecutive conflict cycles won by data.
//   clk, resetn                  : clock, synchronous active-low reset
//   inst_req/addr -> inst_gnt    : fetch request / grant
//   inst_rvalid/rdata            : fetch response (data held between responses)
//   data_req/wen/addr/wdata      : load/store request, data_gnt grant
//   data_rvalid/rdata            : load response (data held between responses)
//   sram_en/wen/addr/wdata       : SRAM command, driven in the grant cycle
//   sram_rdata                   : SRAM read data, one cycle after a read
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic [3:0] r_starve_cnt;
    logic       w_starve_max;
    logic       w_inst_gnt;
    logic       w_data_gnt;

    assign w_starve_max = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Data normally wins; a fetch that has waited STARVE_LIMIT conflicts wins.
    assign w_data_gnt = resetn && data_req && !(inst_req && w_starve_max);
    assign w_inst_gnt = resetn && inst_req && !w_data_gnt;

    assign inst_gnt = w_inst_gnt;
    assign data_gnt = w_data_gnt;

    always_ff @(posedge clk) begin
        if (!resetn || !inst_req || w_inst_gnt)
            r_starve_cnt <= '0;
        else if (w_data_gnt && !w_starve_max)
            r_starve_cnt <= r_starve_cnt + 4'd1;
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_inst_gnt) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (w_data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    mem_arb_rsp u_rsp (
        .clk           (clk),
        .resetn        (resetn),
        .i_inst_gnt    (w_inst_gnt),
        .i_data_gnt    (w_data_gnt),
        .i_data_wen    (data_wen),
        .i_sram_rdata  (sram_rdata),
        .o_inst_rvalid (inst_rvalid),
        .o_inst_rdata  (inst_rdata),
        .o_data_rvalid (data_rvalid),
        .o_data_rdata  (data_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// behavioural model. Grants and SRAM commands are checked in the request
// cycle; expected read responses go into per-port queues that a separate
// monitor drains whenever the DUT should present (or withhold) rvalid.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // ---------------- SRAM model (256 words, indexed by addr[9:2]) ----------
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[0]   <= 32'h1111_1111;
            mem[1]   <= 32'h2222_2222;
            mem_init <= 1'b1;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000)
                sram_rdata <= mem[sram_addr[9:2]];
            else
                mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wen);
        end
    end

    // ---------------- reference model + scoreboard --------------------------
    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t iq[$];
    rsp_t dq[$];
    int   m_wait = 0;   // consecutive cycles a fetch has lost to data

    // One request cycle: drive after posedge, check at negedge.
    task automatic step(input logic rn, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd, output logic gi, output logic gd);
        logic ei, ed;
        logic [31:0] ea;
        @(posedge clk);
        #1;
        resetn = rn; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
        @(negedge clk);
        ei = rn && ir && (!dr || m_wait >= LIM);
        ed = rn && dr && !ei;
        ea = ei ? ia : (ed ? da : 32'h0);
        chk("inst_gnt", 32'(inst_gnt), 32'(ei));
        chk("data_gnt", 32'(data_gnt), 32'(ed));
        chk("sram_en", 32'(sram_en), 32'(ei | ed));
        chk("sram_wen", 32'(sram_wen), ed ? 32'(dw) : 32'h0);
        chk("sram_addr", sram_addr, ea);
        chk("sram_wdata", sram_wdata, ed ? dd : 32'h0);
        if (!rn || !ir || ei) m_wait = 0;
        else m_wait++;
        if (ei) iq.push_back('{cyc + 1, mem[ia[9:2]]});
        if (ed && dw == 4'b0000) dq.push_back('{cyc + 1, mem[da[9:2]]});
        gi = inst_gnt;
        gd = data_gnt;
    endtask

    logic [31:0] ihold = '0;
    logic [31:0] dhold = '0;

    always @(negedge clk) begin
        rsp_t e;
        if (!resetn) begin
            chk("rst inst_rvalid", 32'(inst_rvalid), 32'h0);
            chk("rst inst_rdata", inst_rdata, 32'h0);
            chk("rst data_rvalid", 32'(data_rvalid), 32'h0);
            chk("rst data_rdata", data_rdata, 32'h0);
            iq.delete();
            dq.delete();
            ihold = '0;
            dhold = '0;
        end else begin
            if (iq.size() > 0 && iq[0].cyc == cyc) begin
                e = iq.pop_front();
                chk("inst_rvalid", 32'(inst_rvalid), 32'h1);
                chk("inst_rdata", inst_rdata, e.data);
                ihold = e.data;
            end else begin
                chk("inst_rvalid idle", 32'(inst_rvalid), 32'h0);
                chk("inst_rdata hold", inst_rdata, ihold);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                e = dq.pop_front();
                chk("data_rvalid", 32'(data_rvalid), 32'h1);
                chk("data_rdata", data_rdata, e.data);
                dhold = e.data;
            end else begin
                chk("data_rvalid idle", 32'(data_rvalid), 32'h0);
                chk("data_rdata hold", data_rdata, dhold);
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        logic gi, gd;
        logic [5:0] ipat, dpat;
        logic ip, dp;
        logic [31:0] ra, rda, rdd;
        logic [3:0] rdw;
        logic [31:0] atab [6];
        atab[0] = 32'hbfc0_0000; atab[1] = 32'hbfc0_0004; atab[2] = 32'h0000_0100;
        atab[3] = 32'h0000_0104; atab[4] = 32'h0000_0200; atab[5] = 32'h0000_0204;

        // reset with requests asserted: grants must stay low
        step(0, 1, 32'hbfc0_0000, 1, 4'h0, 32'h100, 32'h0, gi, gd);
        step(0, 1, 32'hbfc0_0000, 1, 4'h0, 32'h100, 32'h0, gi, gd);
        chk("rst starve_cnt", 32'(dut.r_starve_cnt), 32'h0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);

        // fetch only, back to back
        step(1, 1, 32'hbfc0_0000, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("fetch1 gnt", 32'(gi), 32'h1);
        step(1, 1, 32'hbfc0_0004, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("fetch2 gnt", 32'(gi), 32'h1);
        chk("fetch1 rvalid", 32'(inst_rvalid), 32'h1);
        chk("fetch1 rdata", inst_rdata, 32'h1111_1111);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("fetch2 rvalid", 32'(inst_rvalid), 32'h1);
        chk("fetch2 rdata", inst_rdata, 32'h2222_2222);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("fetch held rvalid", 32'(inst_rvalid), 32'h0);
        chk("fetch held rdata", inst_rdata, 32'h2222_2222);

        // load/fetch conflict
        step(1, 1, 32'hbfc0_0004, 1, 4'h0, 32'h104, 32'h0, gi, gd);
        chk("conflict gnts", 32'({gi, gd}), 32'h1);
        step(1, 1, 32'hbfc0_0004, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("conflict fetch gnt", 32'(gi), 32'h1);
        chk("conflict load rvalid", 32'(data_rvalid), 32'h1);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);

        // starvation: both held 6 cycles
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 32'hbfc0_0000, 1, 4'h0, 32'h200, 32'h0, gi, gd);
            ipat[k] = gi;
            dpat[k] = gd;
        end
        chk("starve inst pattern", 32'(ipat), 32'h10);
        chk("starve data pattern", 32'(dpat), 32'h2f);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);

        // partial store then read back
        step(1, 0, 32'h0, 1, 4'b0011, 32'h100, 32'hdead_beef, gi, gd);
        chk("store sram_wen", 32'(sram_wen), 32'h3);
        chk("store sram_addr", sram_addr, 32'h100);
        chk("store sram_wdata", sram_wdata, 32'hdead_beef);
        step(1, 0, 32'h0, 1, 4'h0, 32'h100, 32'h0, gi, gd);
        chk("store no rvalid", 32'(data_rvalid), 32'h0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("store readback", data_rdata, 32'hC0DE_BEEF);

        // reset mid-read (fetch granted, then reset)
        step(1, 1, 32'hbfc0_0000, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        step(0, 1, 32'hbfc0_0000, 1, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("midrst inst_rvalid", 32'(inst_rvalid), 32'h0);
        chk("midrst inst_rdata", inst_rdata, 32'h0);
        // build up starvation, then reset
        step(1, 1, 32'hbfc0_0000, 1, 4'h0, 32'h104, 32'h0, gi, gd);
        step(1, 1, 32'hbfc0_0000, 1, 4'h0, 32'h104, 32'h0, gi, gd);
        step(0, 1, 32'hbfc0_0000, 1, 4'h0, 32'h104, 32'h0, gi, gd);
        step(0, 1, 32'hbfc0_0000, 1, 4'h0, 32'h104, 32'h0, gi, gd);
        chk("midrst starve_cnt", 32'(dut.r_starve_cnt), 32'h0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("post-rst inst_rvalid", 32'(inst_rvalid), 32'h0);
        chk("post-rst data_rvalid", 32'(data_rvalid), 32'h0);

        // randomized traffic; requests held until granted
        ip = 0; dp = 0; ra = '0; rda = '0; rdd = '0; rdw = '0;
        for (int n = 0; n < 500; n++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1;
                ra = atab[$urandom_range(0, 5)];
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp  = 1;
                rda = atab[$urandom_range(0, 5)];
                rdw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                rdd = $urandom;
            end
            step(($urandom_range(0, 59) != 0), ip, ra, dp, rdw, rda, rdd, gi, gd);
            if (gi) ip = 0;
            if (gd) dp = 0;
        end
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("queues drained", 32'(iq.size() + dq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
